// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: next-PC op codes, reset PC,
// fetch FSM states, F/D bundle and jump/branch target helpers.
package pipe_pkg;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_3000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // Branch target: word offset relative to the delay slot.
    function automatic logic [31:0] br_target(
        input logic [31:0] pc,
        input logic [15:0] imm16
    );
        return pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // Jump target: region bits of the jump PC, then index.
    function automatic logic [31:0] j_target(
        input logic [3:0]  pc_hi,
        input logic [25:0] idx
    );
        return {pc_hi, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/response bundle between the
// fetch sequencer (master) and the instruction memory (slave).
interface fetch_pc_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/npc_target.sv
// D-stage redirect decode: decides whether the D instruction
// redirects fetch this cycle and computes where to.
module npc_target
    import pipe_pkg::*;
(
    input  logic        stall,
    input  logic        d_valid,
    input  logic [2:0]  d_npc_op,
    input  logic        d_need_b,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs_data,
    output logic        redir,
    output logic [31:0] target
);

    logic take;

    // Decode op; unused encodings behave as sequential.
    always_comb begin
        take   = 1'b0;
        target = 32'h0;
        case (d_npc_op)
            NPC_BR: begin
                take   = d_need_b;
                target = br_target(d_pc, d_imm26[15:0]);
            end
            NPC_J: begin
                take   = 1'b1;
                target = j_target(d_pc[31:28], d_imm26);
            end
            NPC_JR: begin
                take   = 1'b1;
                target = d_rs_data;
            end
            default: begin
                take   = 1'b0;
                target = 32'h0;
            end
        endcase
    end

    assign redir = d_valid & ~stall & take;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC sequencer: owns the PC, runs the imem handshake
// and defers D-stage redirects until the delay slot is taken.
module fetch_pc_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   d_valid,
    input  logic [2:0]             d_npc_op,
    input  logic                   d_need_b,
    input  logic [31:0]            d_pc,
    input  logic [25:0]            d_imm26,
    input  logic [31:0]            d_rs_data,
    fetch_pc_ctrl_if.master        imem,
    output logic                   f_valid,
    output logic [31:0]            f_pc,
    output logic [31:0]            f_instr
);

    localparam logic [0:0] ST_FETCH = 1'(FETCH);
    localparam logic [0:0] ST_HOLD  = 1'(HOLD);

    logic [0:0]  state;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] ibuf;

    logic        redir;
    logic [31:0] redir_target;
    logic        acc;
    logic [31:0] npc;
    if_id_t      f_out;

    npc_target u_npc_target (
        .stall     (stall),
        .d_valid   (d_valid),
        .d_npc_op  (d_npc_op),
        .d_need_b  (d_need_b),
        .d_pc      (d_pc),
        .d_imm26   (d_imm26),
        .d_rs_data (d_rs_data),
        .redir     (redir),
        .target    (redir_target)
    );

    // Per-state outputs; reset masks request and valid.
    always_comb begin
        f_out.valid    = 1'b0;
        f_out.pc       = pc;
        f_out.instr    = imem.imem_rdata;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        unique case (state)
            ST_FETCH: begin
                imem.imem_req = ~reset;
                f_out.valid   = ~reset & imem.imem_ready;
            end
            ST_HOLD: begin
                f_out.valid = ~reset;
                f_out.instr = ibuf;
            end
            default: begin
                f_out.valid = 1'b0;
            end
        endcase
    end

    assign f_valid = f_out.valid;
    assign f_pc    = f_out.pc;
    assign f_instr = f_out.instr;

    assign acc = f_valid & ~stall;

    // A buffered redirect outranks one arriving now.
    always_comb begin
        if (pend_valid) begin
            npc = pend_target;
        end else if (redir) begin
            npc = redir_target;
        end else begin
            npc = pc + 32'd4;
        end
    end

    // PC advances only when D takes the offered instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (acc) begin
            pc <= npc;
        end
    end

    // Fetch FSM: park a stalled response in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (imem.imem_ready & stall) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (~stall) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Instruction buffer keeps a response D could not take.
    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf <= 32'h0;
        end else if (state == ST_FETCH && imem.imem_ready && stall) begin
            ibuf <= imem.imem_rdata;
        end
    end

    // Pending target: a redirect before its delay slot is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (acc & pend_valid) begin
            pend_valid <= 1'b0;
        end else if (redir & ~acc & ~pend_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: vector table plus
// hand sequences for slow memory, stall hold and reset.
module tb_fetch_pc_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        d_valid;
    logic [2:0]  d_npc_op;
    logic        d_need_b;
    logic [31:0] d_pc;
    logic [25:0] d_imm26;
    logic [31:0] d_rs_data;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        corrupt;
    logic [15:0] cyc = 16'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    fetch_pc_ctrl_if imem();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem.imem_rdata = corrupt ? {16'hBAD0, cyc}
                                     : mem_word(imem.imem_addr);

    fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .d_valid   (d_valid),
        .d_npc_op  (d_npc_op),
        .d_need_b  (d_need_b),
        .d_pc      (d_pc),
        .d_imm26   (d_imm26),
        .d_rs_data (d_rs_data),
        .imem      (imem.master),
        .f_valid   (f_valid),
        .f_pc      (f_pc),
        .f_instr   (f_instr)
    );

    // A second redirect before the first target is used is illegal.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(dut.pend_valid && d_valid && !stall &&
                      (d_npc_op == 3'd2 || d_npc_op == 3'd3 ||
                       (d_npc_op == 3'd1 && d_need_b))))
            else $error("FAIL redir_while_pending");
        end
    end

    typedef struct {
        logic        st;
        logic        rdy;
        logic        cor;
        logic        dv;
        logic [2:0]  op;
        logic        nb;
        logic [31:0] dpc;
        logic [25:0] imm;
        logic [31:0] rs;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(
        input logic st, input logic rdy, input logic cor,
        input logic dv, input logic [2:0] op, input logic nb,
        input logic [31:0] dpc, input logic [25:0] imm,
        input logic [31:0] rs, input logic e_req,
        input logic [31:0] e_addr, input logic e_fv,
        input logic [31:0] e_pc
    );
        vec_t v;
        v.st = st; v.rdy = rdy; v.cor = cor;
        v.dv = dv; v.op = op; v.nb = nb;
        v.dpc = dpc; v.imm = imm; v.rs = rs;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_fv = e_fv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rdy,
                         input logic dv, input logic [2:0] op,
                         input logic nb, input logic [31:0] dpc,
                         input logic [25:0] imm, input logic [31:0] rs);
        stall = st; imem.imem_ready = rdy; d_valid = dv;
        d_npc_op = op; d_need_b = nb; d_pc = dpc;
        d_imm26 = imm; d_rs_data = rs;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, rdy, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
    endtask

    // Called at a negedge with inputs applied; checks, then
    // moves on to the next negedge.
    task automatic expect_cyc(input string tag, input logic e_req,
                              input logic [31:0] e_addr,
                              input logic e_fv,
                              input logic [31:0] e_pc);
        #1;
        chk({tag, ".req"}, 32'(imem.imem_req), 32'(e_req));
        if (e_req) chk({tag, ".addr"}, imem.imem_addr, e_addr);
        chk({tag, ".fv"}, 32'(f_valid), 32'(e_fv));
        chk({tag, ".fpc"}, f_pc, e_pc);
        if (e_fv) chk({tag, ".instr"}, f_instr, mem_word(e_pc));
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        corrupt = 1'b0;
        idle(1'b1);
        @(negedge clk);
        #1;
        chk({tag, ".rst_req"}, 32'(imem.imem_req), 32'h0);
        chk({tag, ".rst_fv"}, 32'(f_valid), 32'h0);
        chk({tag, ".rst_pc"}, imem.imem_addr, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        corrupt = 1'b0;
        idle(1'b1);

        vt[0]  = mk(0,1,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h3000, 1, 32'h3000);
        vt[1]  = mk(0,1,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h3004, 1, 32'h3004);
        vt[2]  = mk(0,1,0, 1,3'd1,1, 32'h3000, 26'h0003,   32'h0,
                    1, 32'h3008, 1, 32'h3008);
        vt[3]  = mk(0,1,0, 1,3'd1,1, 32'h3000, 26'h0FFFF,  32'h0,
                    1, 32'h3010, 1, 32'h3010);
        vt[4]  = mk(0,1,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h3000, 1, 32'h3000);
        vt[5]  = mk(0,1,0, 1,3'd1,0, 32'h3000, 26'h0003,   32'h4000,
                    1, 32'h3004, 1, 32'h3004);
        vt[6]  = mk(0,1,0, 1,3'd3,0, 32'h3004, 26'h0,      32'h4000,
                    1, 32'h3008, 1, 32'h3008);
        vt[7]  = mk(0,1,0, 1,3'd4,1, 32'h4000, 26'h0010,   32'h9000,
                    1, 32'h4000, 1, 32'h4000);
        vt[8]  = mk(1,1,0, 1,3'd2,0, 32'h3008, 26'h0C10,   32'h0,
                    1, 32'h4004, 1, 32'h4004);
        vt[9]  = mk(1,1,1, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    0, 32'h0,    1, 32'h4004);
        vt[10] = mk(0,0,1, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    0, 32'h0,    1, 32'h4004);
        vt[11] = mk(0,1,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h4008, 1, 32'h4008);
        vt[12] = mk(0,0,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h400C, 0, 32'h400C);
        vt[13] = mk(0,1,0, 1,3'd7,1, 32'h400C, 26'h0020,   32'h8000,
                    1, 32'h400C, 1, 32'h400C);
        vt[14] = mk(0,1,0, 0,3'd0,0, 32'h0,    26'h0,      32'h0,
                    1, 32'h4010, 1, 32'h4010);

        @(negedge clk);
        do_reset("tbl");
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].st, vt[i].rdy, vt[i].dv, vt[i].op,
                  vt[i].nb, vt[i].dpc, vt[i].imm, vt[i].rs);
            corrupt = vt[i].cor;
            expect_cyc($sformatf("v%0d", i), vt[i].e_req,
                       vt[i].e_addr, vt[i].e_fv, vt[i].e_pc);
        end
        corrupt = 1'b0;

        // Jump while memory waits: slot 0x300C first, then 0x3040.
        do_reset("jmp");
        idle(1'b1);
        expect_cyc("j0", 1, 32'h3000, 1, 32'h3000);
        expect_cyc("j1", 1, 32'h3004, 1, 32'h3004);
        expect_cyc("j2", 1, 32'h3008, 1, 32'h3008);
        drive(0, 0, 1, 3'd2, 0, 32'h3008, 26'h0000C10, 32'h0);
        expect_cyc("j3", 1, 32'h300C, 0, 32'h300C);
        chk("j.pend_set", 32'(dut.pend_valid), 32'h1);
        idle(1'b0);
        expect_cyc("j4", 1, 32'h300C, 0, 32'h300C);
        expect_cyc("j5", 1, 32'h300C, 0, 32'h300C);
        idle(1'b1);
        expect_cyc("j6", 1, 32'h300C, 1, 32'h300C);
        chk("j.pend_clr", 32'(dut.pend_valid), 32'h0);
        expect_cyc("j7", 1, 32'h3040, 1, 32'h3040);

        // Stall on a ready response: held four cycles.
        do_reset("stl");
        idle(1'b1);
        expect_cyc("s0", 1, 32'h3000, 1, 32'h3000);
        drive(1, 1, 0, 3'd0, 0, 32'h0, 26'h0, 32'h0);
        expect_cyc("s1", 1, 32'h3004, 1, 32'h3004);
        corrupt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_cyc($sformatf("s_hold%0d", k), 0, 32'h0, 1, 32'h3004);
        end
        idle(1'b1);
        expect_cyc("s_rel", 0, 32'h0, 1, 32'h3004);
        corrupt = 1'b0;
        expect_cyc("s_next", 1, 32'h3008, 1, 32'h3008);

        // Reset in HOLD with a pending jr target 0x5000.
        do_reset("mid");
        drive(0, 0, 1, 3'd3, 0, 32'h2FFC, 26'h0, 32'h5000);
        expect_cyc("m0", 1, 32'h3000, 0, 32'h3000);
        drive(1, 1, 0, 3'd0, 0, 32'h0, 26'h0, 32'h0);
        expect_cyc("m1", 1, 32'h3000, 1, 32'h3000);
        chk("m.pend", 32'(dut.pend_valid), 32'h1);
        chk("m.ptgt", dut.pend_target, 32'h5000);
        expect_cyc("m2", 0, 32'h0, 1, 32'h3000);
        do_reset("mrst");
        chk("m.pend_rst", 32'(dut.pend_valid), 32'h0);
        idle(1'b1);
        expect_cyc("m3", 1, 32'h3000, 1, 32'h3000);
        expect_cyc("m4", 1, 32'h3004, 1, 32'h3004);
        expect_cyc("m5", 1, 32'h3008, 1, 32'h3008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage PC sequencer for the five-stage MIPS pipeline. It owns the F-stage PC register and runs the instruction-memory request handshake. It absorbs D-stage redirects (branch/j/jal/jr) with a one-entry pending-target buffer, so the branch delay slot is always fetched before the redirect takes effect. It sits between the hazard unit, the D-stage next-PC decode and the instruction memory, and presents `f_valid/f_pc/f_instr` to the F/D register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC fetched first after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit freezes the F→D transfer.
- `d_valid` in 1: D stage holds a real instruction, not a bubble.
- `d_npc_op` in 3: 0 = sequential, 1 = branch, 2 = j/jal, 3 = jr/jalr; 4–7 = sequential.
- `d_need_b` in 1: branch condition true.
- `d_pc` in 32: PC of the D-stage instruction.
- `d_imm26` in 26: instr[25:0].
- `d_rs_data` in 32: forwarded rs value.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ready` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `f_valid` out 1, `f_pc` out 32, `f_instr` out 32: instruction offered to D.

## Operation
- **Redirect event:** `redir = d_valid & ~stall & (op==2 | op==3 | (op==1 & d_need_b))`.
- **Targets:** all mod 2^32, with no alignment fixup.
  - Branch: `d_pc + 4 + {{14{imm26[15]}}, imm26[15:0], 2'b00}`.
  - Jump: `{d_pc[31:28], imm26, 2'b00}`.
  - jr: `d_rs_data`.
- **Accept:** `acc = f_valid & ~stall`. On `acc`, the next PC is chosen in this priority order:
  1. `pend_target` if `pend_valid`; clear `pend_valid`.
  2. Else the target, if `redir` this cycle.
  3. Else `pc + 4`.
- **Redirect without accept:** `redir & ~acc` sets `pend_valid` and stores the target. The delay slot (the current `pc`) is still fetched and delivered first.
- **Redirect while pending:** `redir` while `pend_valid` cannot legally occur, because D holds a bubble until the delay slot is accepted. If it does occur, RTL keeps the first target and the bench flags it by assertion.
- **FSM, state FETCH:**
  - Outputs: `imem_req=1`, `imem_addr=pc`, `f_valid=imem_ready`, `f_instr=imem_rdata` (pass-through), `f_pc=pc`.
  - `imem_ready & ~stall`: advance PC, stay in FETCH.
  - `imem_ready & stall`: capture `imem_rdata` into `ibuf`, go to HOLD.
  - `~imem_ready`: stay in FETCH, hold `pc`.
- **FSM, state HOLD:**
  - Outputs: `imem_req=0`, `f_valid=1`, `f_instr=ibuf`, `f_pc=pc`.
  - `~stall`: advance PC, go to FETCH.
- **Reset:**
  - Registers: `pc=RESET_PC`, state FETCH, `pend_valid=0`, `pend_target=0`, `ibuf=0`.
  - Outputs while `reset` is high: `imem_req=0`, `f_valid=0`.
  - Reset mid-handshake discards the in-flight fetch and any pending redirect.

## Timing
- Zero-wait memory sustains one instruction per cycle. Each wait cycle adds one cycle.
- First cycle after `reset` falls: `imem_req=1`, `imem_addr=RESET_PC`.
- A redirect seen in cycle t with delay slot accepted in t: target address appears on `imem_addr` at t+1.
- If the delay slot is accepted at t+k instead, the target appears at t+k+1.
- `f_valid` stays high and `f_pc/f_instr` stay stable for as long as `stall` is held in HOLD.
- `imem_req` drops while in HOLD. No new fetch is issued until the held instruction is accepted.

## Structure
- **Shared package `pipe_pkg`:**
  - `NPC_SEQ=0`, `NPC_BR=1`, `NPC_J=2`, `NPC_JR=3`.
  - `RESET_PC` default.
  - Fetch state enum {FETCH, HOLD}.
- **Sub-module `npc_target`:** combinational; computes `redir` and the target from the D-stage inputs. `fetch_pc_ctrl` instantiates it once.
- **Registers:** the PC register, pending buffer, `ibuf` and FSM live in `fetch_pc_ctrl`.

## Test plan
- **Reset, ready tied high, no stall:** `imem_addr` reads 0x3000, 0x3004, 0x3008 on consecutive cycles; `f_valid=1` each cycle.
- **Taken branch:**
  - Stimulus: `d_pc=0x3000`, `imm16=0x0003`, `d_need_b=1`, delay slot accepted in the same cycle.
  - Required response: next `imem_addr=0x3010`.
  - Repeat with `imm16=0xFFFF`: next address 0x3000.
- **Jump with slow memory:**
  - Stimulus: jump with `d_pc=0x3008`, `imm26=0x0000C10`, `imem_ready=0` for 3 cycles.
  - Required response: `pend_valid` set; the delay slot at 0x300C is delivered first; then `imem_addr=0x3040`.
- **Stall on ready:** `stall=1` for 4 cycles with `imem_ready=1` at 0x3004 → HOLD, `imem_req=0`, `f_instr` stable; after release, the next fetch is 0x3008.
- **jr:** `d_rs_data=0x0000_4000`, not taken, `op=1`, `need_b=0` → sequential 0x3008. Then jr → 0x4000 after the delay slot.
- **Reset mid-operation:** `reset` asserted while in HOLD with a pending target 0x5000 → after release, fetch restarts at 0x3000, never 0x5000.
